alu_wb_stage: RTL and testbench
===============================

Name: alu_wb_stage

Overview:
- Writeback stage directly downstream of the Alu.
- Accepts each ALU result (out, flags_out) plus destination info into a small in-order FIFO.
- Arbitrates onto the shared register-file write port via a req/grant handshake and commits the architectural flags register.
- The committed flags (flags_q) feed back to the Alu flags_in, supplying carry for Adc/Sbc.

Parameters:
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the retire statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  ALU result valid.
- in_ready  out  1  stage can accept.
- in_result  in  CPU_WORD_W (32)  Alu out.
- in_flags  in  CPU_FLAGS_W (4)  Alu flags_out.
- in_dest  in  CPU_REG_IDX_W (4)  destination register index.
- in_write_reg  in  1  result is written to the register file.
- in_write_flags  in  1  flags are committed.
- rf_req  out  1  register-file write request.
- rf_grant  in  1  register-file port granted this cycle.
- rf_waddr  out  4  write address.
- rf_wdata  out  32  write data.
- flags_q  out  4  committed flags, to Alu flags_in.
- flags_pending  out  1  some queued entry has write_flags=1.
- busy  out  1  FIFO non-empty.
- retire_cnt  out  CNT_W  retired-entry count.

Behaviour:
- Reset (async assert, sync release):
  - count=0, pointers=0, flags_q=4'b0000, retire_cnt=0.
  - rf_req=0, rf_waddr=0, rf_wdata=0.
  - in_ready=1, busy=0, flags_pending=0.
- Accept: in_valid && in_ready at a rising edge; the entry is written at the tail.
  - in_ready = (count != DEPTH). It does not look at same-cycle retire, so a full FIFO never accepts, even if the head retires that cycle.
- Latency: an entry accepted into an empty FIFO becomes head on the next cycle. Its rf_req asserts combinationally that cycle, so accept-to-request is 1 cycle.
- Head with write_reg=1:
  - rf_req=1; rf_waddr/rf_wdata are driven from the head entry.
  - The entry retires on the edge where rf_grant=1.
  - While rf_grant=0, the head holds and rf_waddr/rf_wdata stay stable.
- Head with write_reg=0: rf_req=0, and the entry retires at the first edge it is head (1 cycle).
- Retire:
  - Pop head.
  - If head.write_flags, flags_q <= head.flags at the same edge; otherwise flags_q is unchanged.
  - retire_cnt += 1, wrapping modulo 2^CNT_W (0xFFFF -> 0x0000).
- Simultaneous accept and retire (count neither 0 nor DEPTH): count unchanged, both pointers advance.
- Empty FIFO: rf_req=0 and rf_grant is ignored.
- rf_grant is ignored whenever rf_req=0.
- Pointers wrap modulo DEPTH.
- Entries retire strictly in acceptance order.
- flags_pending = OR of write_flags over valid entries (combinational). Issue logic stalls flag-consuming ops (Adc/Sbc) while it is 1.
- Entries with in_write_reg=0 and in_write_flags=0 are still queued and retired. This preserves ordering and retire_cnt.
- Reset mid-operation discards every queued entry: no partial writes, and flags_q returns to 0.

Decomposition:
- pkg_cpu constants: CPU_WORD_W=32, CPU_FLAGS_W=4, CPU_REG_IDX_W=4, flag bit positions (C=bit 0).
- pkg_cpu typedef: struct StrcWbEntry {result, flags, dest, write_reg, write_flags}.
- Sub-module wb_fifo (parameterised DEPTH, entry type StrcWbEntry).
  - Interface: push/pop/full/empty/head plus a per-entry valid/write_flags vector for flags_pending.
- Arbitration, flags register and counter live in alu_wb_stage.

Test Plan:
1. Single write: push {result=0x00000031, flags=4'b0001, dest=3, wr=1, wf=1}, rf_grant=1 held.
   -> rf_req=1 with waddr=3, wdata=0x31 on cycle+1; flags_q=0001 and retire_cnt=1 after that edge.
2. Backpressure: rf_grant=0 for 5 cycles, push 3 entries.
   -> in_ready=0 after the 2nd accept (DEPTH=2); rf_waddr/wdata stable for all 5 cycles.
   -> Release grant: writes in order, third entry accepted once count<2.
3. Flags-only entry (wr=0, wf=1, flags=4'b1000).
   -> rf_req never asserts; flags_q=1000 one cycle after head; flags_pending drops the same edge.
4. Concurrent push/pop at count=1 with grant=1 every cycle, 10 back-to-back pushes.
   -> in_ready stays 1; 10 writes in order; retire_cnt=10.
5. Async reset asserted while 2 entries are queued and grant=0.
   -> Immediately rf_req=0, busy=0, flags_q=0; no write occurs after release.
6. Counter wrap with CNT_W=4: 17 retires -> retire_cnt=1.

Source files
------------

// File: rtl/alu_wb_stage_pkg.sv
// Shared CPU datapath constants and the writeback queue entry payload.
package alu_wb_stage_pkg;

    localparam int unsigned CPU_WORD_W    = 32;
    localparam int unsigned CPU_FLAGS_W   = 4;
    localparam int unsigned CPU_REG_IDX_W = 4;

    // Flag bit positions inside the flags nibble.
    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_N = 3;

    typedef struct packed {
        logic [CPU_WORD_W-1:0]    result;
        logic [CPU_FLAGS_W-1:0]   flags;
        logic [CPU_REG_IDX_W-1:0] dest;
        logic                     write_reg;
        logic                     write_flags;
    } wb_entry_t;

endpackage

// File: rtl/alu_wb_stage_fifo.sv
// In-order FIFO of writeback entries; exposes per-slot pending-flag bits.
module alu_wb_stage_fifo
    import alu_wb_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  wb_entry_t        din,
    input  logic             pop,
    output logic             full_c,
    output logic             empty_c,
    output wb_entry_t        head_c,
    output logic [DEPTH-1:0] pending_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full_c  = (count == CNT_W'(DEPTH));
    assign empty_c = (count == '0);
    assign do_push = push && !full_c;
    assign do_pop  = pop && !empty_c;
    assign head_c  = mem[rptr];

    always_comb begin
        pending_c = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            pending_c[i] = vld[i] && mem[i].write_flags;
        end
    end

    // Storage, pointers and occupancy; pointers wrap naturally at power-of-two DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            vld   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_pop) begin
                vld[rptr] <= 1'b0;
                rptr      <= rptr + PTR_W'(1);
            end
            if (do_push) begin
                mem[wptr] <= din;
                vld[wptr] <= 1'b1;
                wptr      <= wptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: queues results, arbitrates for the RF write port,
// commits the architectural flags and counts retired entries.
module alu_wb_stage
    import alu_wb_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CPU_WORD_W-1:0]    in_result,
    input  logic [CPU_FLAGS_W-1:0]   in_flags,
    input  logic [CPU_REG_IDX_W-1:0] in_dest,
    input  logic                     in_write_reg,
    input  logic                     in_write_flags,
    output logic                     rf_req,
    input  logic                     rf_grant,
    output logic [CPU_REG_IDX_W-1:0] rf_waddr,
    output logic [CPU_WORD_W-1:0]    rf_wdata,
    output logic [CPU_FLAGS_W-1:0]   flags_q,
    output logic                     flags_pending,
    output logic                     busy,
    output logic [CNT_W-1:0]         retire_cnt
);

    wb_entry_t        din;
    wb_entry_t        head;
    logic             full;
    logic             empty;
    logic             retire;
    logic [DEPTH-1:0] pending;

    assign din = '{result:      in_result,
                   flags:       in_flags,
                   dest:        in_dest,
                   write_reg:   in_write_reg,
                   write_flags: in_write_flags};

    alu_wb_stage_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid),
        .din       (din),
        .pop       (retire),
        .full_c    (full),
        .empty_c   (empty),
        .head_c    (head),
        .pending_c (pending)
    );

    // Ready ignores a same-cycle retire so the accept path stays independent of rf_grant.
    assign in_ready      = !full;
    assign busy          = !empty;
    assign flags_pending = |pending;

    assign rf_req   = !empty && head.write_reg;
    assign rf_waddr = rf_req ? head.dest : '0;
    assign rf_wdata = rf_req ? head.result : '0;

    // Register writes wait for the grant; flags-only and no-op entries retire immediately.
    assign retire = !empty && (!head.write_reg || rf_grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q    <= '0;
            retire_cnt <= '0;
        end else if (retire) begin
            if (head.write_flags) begin
                flags_q <= head.flags;
            end
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed self-checking bench for alu_wb_stage; a second instance with a
// 4-bit retire counter shares the stimulus to exercise counter wrap.
module tb_alu_wb_stage;
    import alu_wb_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_result = '0;
    logic [3:0]  in_flags = '0;
    logic [3:0]  in_dest = '0;
    logic        in_write_reg = 1'b0;
    logic        in_write_flags = 1'b0;
    logic        rf_grant = 1'b0;

    logic        in_ready, rf_req, flags_pending, busy;
    logic [3:0]  rf_waddr, flags_q;
    logic [31:0] rf_wdata;
    logic [15:0] retire_cnt;

    logic        in_ready4, rf_req4, flags_pending4, busy4;
    logic [3:0]  rf_waddr4, flags_q4;
    logic [31:0] rf_wdata4;
    logic [3:0]  retire_cnt4;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    alu_wb_stage #(.DEPTH(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flags(in_flags), .in_dest(in_dest),
        .in_write_reg(in_write_reg), .in_write_flags(in_write_flags),
        .rf_req(rf_req), .rf_grant(rf_grant), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flags_q(flags_q), .flags_pending(flags_pending), .busy(busy), .retire_cnt(retire_cnt)
    );

    alu_wb_stage #(.DEPTH(2), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_result(in_result), .in_flags(in_flags), .in_dest(in_dest),
        .in_write_reg(in_write_reg), .in_write_flags(in_write_flags),
        .rf_req(rf_req4), .rf_grant(rf_grant), .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4),
        .flags_q(flags_q4), .flags_pending(flags_pending4), .busy(busy4), .retire_cnt(retire_cnt4)
    );

    task automatic drive_push(input logic [31:0] r, input logic [3:0] f, input logic [3:0] d,
                              input logic wr, input logic wf);
        in_valid = 1'b1; in_result = r; in_flags = f; in_dest = d;
        in_write_reg = wr; in_write_flags = wf;
    endtask

    task automatic drive_idle;
        in_valid = 1'b0; in_result = '0; in_flags = '0; in_dest = '0;
        in_write_reg = 1'b0; in_write_flags = 1'b0;
    endtask

    // Ends on a falling edge with reset released.
    task automatic apply_reset;
        rst_n = 1'b0; rf_grant = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        apply_reset();
        #1;
        checks++; if ({in_ready, busy, rf_req, flags_pending} !== 4'b1000) begin
            fails++; $display("FAIL reset_ctl: got %b expected 1000", {in_ready, busy, rf_req, flags_pending}); end
        checks++; if (flags_q !== 4'b0000) begin
            fails++; $display("FAIL reset_flags: got %b expected 0000", flags_q); end
        checks++; if (retire_cnt !== 16'd0) begin
            fails++; $display("FAIL reset_cnt: got %0d expected 0", retire_cnt); end
        checks++; if ({rf_waddr, rf_wdata} !== 36'd0) begin
            fails++; $display("FAIL reset_wport: got %h/%h expected 0/0", rf_waddr, rf_wdata); end
    endtask

    task automatic test_single_write;
        apply_reset();
        rf_grant = 1'b1;
        drive_push(32'h0000_0031, 4'b0001, 4'd3, 1'b1, 1'b1);
        #1;
        checks++; if (rf_req !== 1'b0) begin
            fails++; $display("FAIL single_req_empty: got %b expected 0", rf_req); end
        @(negedge clk);
        drive_idle();
        #1;
        checks++; if ({rf_req, rf_waddr, rf_wdata} !== {1'b1, 4'd3, 32'h31}) begin
            fails++; $display("FAIL single_wport: got %b/%h/%h expected 1/3/00000031", rf_req, rf_waddr, rf_wdata); end
        checks++; if ({flags_q, flags_pending} !== {4'b0000, 1'b1}) begin
            fails++; $display("FAIL single_pre_flags: got %b/%b expected 0000/1", flags_q, flags_pending); end
        @(negedge clk);
        checks++; if (flags_q !== 4'b0001) begin
            fails++; $display("FAIL single_flags: got %b expected 0001", flags_q); end
        checks++; if ({retire_cnt, busy, rf_req} !== {16'd1, 1'b0, 1'b0}) begin
            fails++; $display("FAIL single_retire: got cnt=%0d busy=%b req=%b expected 1/0/0", retire_cnt, busy, rf_req); end
    endtask

    task automatic test_backpressure;
        apply_reset();
        rf_grant = 1'b0;
        drive_push(32'hA1, 4'b0000, 4'd1, 1'b1, 1'b0);
        @(negedge clk);
        drive_push(32'hB2, 4'b0000, 4'd2, 1'b1, 1'b0);
        #1;
        checks++; if ({in_ready, rf_req, rf_waddr} !== {1'b1, 1'b1, 4'd1}) begin
            fails++; $display("FAIL bp_second_accept: got %b/%b/%h expected 1/1/1", in_ready, rf_req, rf_waddr); end
        @(negedge clk);
        drive_push(32'hC3, 4'b0000, 4'd3, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if ({in_ready, rf_req, rf_waddr, rf_wdata} !== {1'b0, 1'b1, 4'd1, 32'hA1}) begin
                fails++; $display("FAIL bp_hold[%0d]: got rdy=%b req=%b %h/%h expected 0/1/1/a1", k, in_ready, rf_req, rf_waddr, rf_wdata); end
            @(negedge clk);
        end
        rf_grant = 1'b1;
        @(negedge clk);
        #1;
        checks++; if ({in_ready, rf_waddr, rf_wdata, retire_cnt} !== {1'b1, 4'd2, 32'hB2, 16'd1}) begin
            fails++; $display("FAIL bp_release1: got rdy=%b %h/%h cnt=%0d expected 1/2/b2/1", in_ready, rf_waddr, rf_wdata, retire_cnt); end
        @(negedge clk);
        drive_idle();
        #1;
        checks++; if ({busy, rf_waddr, rf_wdata, retire_cnt} !== {1'b1, 4'd3, 32'hC3, 16'd2}) begin
            fails++; $display("FAIL bp_release2: got busy=%b %h/%h cnt=%0d expected 1/3/c3/2", busy, rf_waddr, rf_wdata, retire_cnt); end
        @(negedge clk);
        checks++; if ({busy, rf_req, retire_cnt} !== {1'b0, 1'b0, 16'd3}) begin
            fails++; $display("FAIL bp_drain: got busy=%b req=%b cnt=%0d expected 0/0/3", busy, rf_req, retire_cnt); end
    endtask

    task automatic test_flags_only;
        apply_reset();
        rf_grant = 1'b0;
        drive_push(32'hDEAD_BEEF, 4'b1000, 4'd7, 1'b0, 1'b1);
        @(negedge clk);
        drive_idle();
        #1;
        checks++; if ({rf_req, flags_pending, busy, flags_q} !== {1'b0, 1'b1, 1'b1, 4'b0000}) begin
            fails++; $display("FAIL fo_head: got req=%b pend=%b busy=%b flags=%b expected 0/1/1/0000", rf_req, flags_pending, busy, flags_q); end
        @(negedge clk);
        checks++; if ({rf_req, flags_pending, busy, flags_q} !== {1'b0, 1'b0, 1'b0, 4'b1000}) begin
            fails++; $display("FAIL fo_commit: got req=%b pend=%b busy=%b flags=%b expected 0/0/0/1000", rf_req, flags_pending, busy, flags_q); end
        checks++; if (retire_cnt !== 16'd1) begin
            fails++; $display("FAIL fo_cnt: got %0d expected 1", retire_cnt); end
    endtask

    task automatic test_back_to_back;
        apply_reset();
        rf_grant = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            if (k < 10) drive_push(32'h100 + 32'(k), 4'b0000, 4'(k), 1'b1, 1'b0);
            else        drive_idle();
            #1;
            checks++; if (in_ready !== 1'b1) begin
                fails++; $display("FAIL b2b_ready[%0d]: got %b expected 1", k, in_ready); end
            if (k > 0) begin
                checks++; if ({rf_req, rf_waddr, rf_wdata} !== {1'b1, 4'(k - 1), 32'h100 + 32'(k - 1)}) begin
                    fails++; $display("FAIL b2b_write[%0d]: got %b/%h/%h expected 1/%h/%h", k, rf_req, rf_waddr, rf_wdata, 4'(k - 1), 32'h100 + 32'(k - 1)); end
            end
            @(negedge clk);
        end
        checks++; if ({busy, retire_cnt} !== {1'b0, 16'd10}) begin
            fails++; $display("FAIL b2b_done: got busy=%b cnt=%0d expected 0/10", busy, retire_cnt); end
    endtask

    task automatic test_async_reset;
        apply_reset();
        rf_grant = 1'b0;
        drive_push(32'h55, 4'b0010, 4'd5, 1'b1, 1'b1);
        @(negedge clk);
        drive_push(32'h66, 4'b0010, 4'd6, 1'b1, 1'b1);
        @(negedge clk);
        drive_idle();
        #1;
        checks++; if ({busy, rf_req, flags_pending, in_ready} !== 4'b1110) begin
            fails++; $display("FAIL ar_queued: got %b expected 1110", {busy, rf_req, flags_pending, in_ready}); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({rf_req, busy, flags_pending, in_ready, flags_q, rf_waddr} !== {4'b0001, 4'd0, 4'd0}) begin
            fails++; $display("FAIL ar_immediate: got req=%b busy=%b pend=%b rdy=%b flags=%b addr=%h expected 0/0/0/1/0000/0",
                              rf_req, busy, flags_pending, in_ready, flags_q, rf_waddr); end
        rf_grant = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if ({rf_req, busy, flags_q, retire_cnt} !== {1'b0, 1'b0, 4'd0, 16'd0}) begin
                fails++; $display("FAIL ar_after[%0d]: got req=%b busy=%b flags=%b cnt=%0d expected 0/0/0000/0", k, rf_req, busy, flags_q, retire_cnt); end
        end
    endtask

    task automatic test_counter_wrap;
        apply_reset();
        for (int k = 0; k <= 18; k++) begin
            if (k < 17) drive_push(32'(k), 4'b0000, 4'd0, 1'b0, 1'b0);
            else        drive_idle();
            #1;
            if (k == 17) begin
                checks++; if ({retire_cnt4, retire_cnt} !== {4'd0, 16'd16}) begin
                    fails++; $display("FAIL wrap_16: got cnt4=%0d cnt=%0d expected 0/16", retire_cnt4, retire_cnt); end
            end
            if (k == 18) begin
                checks++; if ({retire_cnt4, retire_cnt} !== {4'd1, 16'd17}) begin
                    fails++; $display("FAIL wrap_17: got cnt4=%0d cnt=%0d expected 1/17", retire_cnt4, retire_cnt); end
            end
            @(negedge clk);
        end
        checks++; if ({busy, rf_req} !== 2'b00) begin
            fails++; $display("FAIL wrap_idle: got busy=%b req=%b expected 0/0", busy, rf_req); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_backpressure();
        test_flags_only();
        test_back_to_back();
        test_async_reset();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
